imem_load_arbiter: RTL and testbench

- Owns the single port of a writable instruction memory and shares it between the pipeline's instruction fetch and a byte-serial program loader (UART/debug side).
- In normal operation, fetch reads the memory combinationally.
- In load mode, the block stalls the CPU, assembles incoming bytes into big-endian words and writes them from word 0 upward.
- On exit from load mode, it requests a pipeline restart at PC 0.

---
 rtl/imem_load_arbiter_if.sv | 36 +++
 rtl/imem_load_arbiter.sv | 166 ++++++++++++++++
 tb/tb_imem_load_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_load_arbiter_if.sv
// Bundle of fetch, loader and instruction-memory signals around imem_load_arbiter.
// The master side is the arbiter; the slave side is the CPU, loader and memory.
interface imem_load_arbiter_if #(
  parameter int ADDR_W = 8
);
  // fetch side
  logic [31:0]       pc;
  logic [31:0]       instr_out;
  logic              cpu_hold;
  logic              cpu_restart;
  // loader side
  logic              ld_start;
  logic              ld_end;
  logic              ld_valid;
  logic [7:0]        ld_byte;
  logic              ld_ready;
  logic [ADDR_W:0]   words_loaded;
  logic              ld_err;
  // memory side
  logic [ADDR_W-1:0] im_addr;
  logic              im_we;
  logic [31:0]       im_wdata;
  logic [31:0]       im_rdata;

  modport master (
    input  pc, ld_start, ld_end, ld_valid, ld_byte, im_rdata,
    output instr_out, cpu_hold, cpu_restart, ld_ready,
           im_addr, im_we, im_wdata, words_loaded, ld_err
  );

  modport slave (
    output pc, ld_start, ld_end, ld_valid, ld_byte, im_rdata,
    input  instr_out, cpu_hold, cpu_restart, ld_ready,
           im_addr, im_we, im_wdata, words_loaded, ld_err
  );
endinterface

// File: rtl/imem_load_arbiter.sv
// Shares the instruction-memory port between combinational fetch and a
// byte-serial program loader that writes big-endian words from address 0.
module imem_load_arbiter #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  imem_load_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   WL_ONE    = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nxt_s;
  logic [1:0]        byte_cnt_r;
  logic [23:0]       shift_r;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W:0]   words_loaded_r;
  logic              ld_err_r;

  logic              accept_s;
  logic              word_done_s;
  logic              last_word_s;
  logic [1:0]        bytes_after_s;

  // A byte is taken only in LOAD, and never alongside a load restart.
  assign accept_s      = (state_r == LOAD) && bus.ld_valid && !bus.ld_start;
  assign word_done_s   = accept_s && (byte_cnt_r == 2'd3);
  assign last_word_s   = (wr_ptr_r == LAST_ADDR);
  assign bytes_after_s = accept_s ? (byte_cnt_r + 2'd1) : byte_cnt_r;

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (bus.ld_start) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LOAD: begin
        if (bus.ld_start) begin
          state_nxt_s = LOAD;
        end else if (word_done_s && last_word_s) begin
          state_nxt_s = FLUSH;
        end else if (bus.ld_end) begin
          state_nxt_s = FLUSH;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      FLUSH: begin
        state_nxt_s = RUN;
      end
      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // Port ownership and handshake outputs; fetch sees memory only in RUN.
  always_comb begin
    bus.instr_out    = bus.im_rdata;
    bus.cpu_hold     = 1'b0;
    bus.cpu_restart  = 1'b0;
    bus.ld_ready     = 1'b0;
    bus.im_addr      = bus.pc[ADDR_W+1:2];
    bus.im_we        = 1'b0;
    bus.im_wdata     = {shift_r, bus.ld_byte};
    bus.words_loaded = words_loaded_r;
    bus.ld_err       = ld_err_r;
    case (state_r)
      RUN: begin
        bus.instr_out = bus.im_rdata;
        bus.im_addr   = bus.pc[ADDR_W+1:2];
      end
      LOAD: begin
        bus.instr_out = NOP_WORD;
        bus.cpu_hold  = 1'b1;
        bus.ld_ready  = 1'b1;
        bus.im_addr   = wr_ptr_r;
        bus.im_we     = word_done_s;
      end
      FLUSH: begin
        bus.instr_out   = NOP_WORD;
        bus.cpu_hold    = 1'b1;
        bus.cpu_restart = 1'b1;
        bus.im_addr     = wr_ptr_r;
      end
      default: begin
        bus.instr_out = NOP_WORD;
        bus.cpu_hold  = 1'b1;
      end
    endcase
  end

  // State register, byte assembly, write pointer and error bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= RUN;
      byte_cnt_r     <= 2'd0;
      shift_r        <= 24'd0;
      wr_ptr_r       <= {ADDR_W{1'b0}};
      words_loaded_r <= {(ADDR_W+1){1'b0}};
      ld_err_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        RUN: begin
          if (bus.ld_start) begin
            byte_cnt_r     <= 2'd0;
            shift_r        <= 24'd0;
            wr_ptr_r       <= {ADDR_W{1'b0}};
            words_loaded_r <= {(ADDR_W+1){1'b0}};
            ld_err_r       <= 1'b0;
          end
        end
        LOAD: begin
          if (bus.ld_start) begin
            byte_cnt_r     <= 2'd0;
            shift_r        <= 24'd0;
            wr_ptr_r       <= {ADDR_W{1'b0}};
            words_loaded_r <= {(ADDR_W+1){1'b0}};
            ld_err_r       <= 1'b0;
          end else begin
            if (word_done_s) begin
              byte_cnt_r     <= 2'd0;
              words_loaded_r <= words_loaded_r + WL_ONE;
              // The pointer parks on the last word so a full load never wraps onto word 0.
              if (!last_word_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
              end
            end else if (accept_s) begin
              shift_r    <= {shift_r[15:0], bus.ld_byte};
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
            if (bus.ld_end && (bytes_after_s != 2'd0)) begin
              byte_cnt_r <= 2'd0;
              ld_err_r   <= 1'b1;
            end
          end
        end
        FLUSH: begin
          if (bus.ld_valid) begin
            ld_err_r <= 1'b1;
          end
        end
        default: begin
          byte_cnt_r <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench for imem_load_arbiter: an ADDR_W=8 instance for fetch/load/abort
// cases and an ADDR_W=2 instance for the memory-full case.
module tb_imem_load_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_load_arbiter_if #(.ADDR_W(8)) bus1 ();
  imem_load_arbiter_if #(.ADDR_W(2)) bus2 ();

  imem_load_arbiter #(.ADDR_W(8), .NOP_WORD(32'h0000_0000)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  imem_load_arbiter #(.ADDR_W(2), .NOP_WORD(32'h0000_0000)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [4];
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;

  always @(posedge clk) begin
    if (pre_we) mem1[pre_addr] <= pre_data;
    else if (bus1.im_we) mem1[bus1.im_addr] <= bus1.im_wdata;
  end

  always @(posedge clk) begin
    if (bus2.im_we) mem2[bus2.im_addr] <= bus2.im_wdata;
  end

  assign bus1.im_rdata = mem1[bus1.im_addr];
  assign bus2.im_rdata = mem2[bus2.im_addr];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic push1(input logic [7:0] b, input int gap, input logic exp_we,
                       input logic [31:0] exp_wd, input logic [31:0] exp_a);
    bus1.ld_valid = 1'b1;
    bus1.ld_byte  = b;
    #2;
    chk("ld_hold", bus1.cpu_hold, 32'd1);
    chk("ld_nop", bus1.instr_out, 32'h0);
    chk("ld_ready", bus1.ld_ready, 32'd1);
    chk("ld_we", bus1.im_we, exp_we);
    if (exp_we) begin
      chk("ld_wdata", bus1.im_wdata, exp_wd);
      chk("ld_waddr", bus1.im_addr, exp_a);
    end
    step();
    bus1.ld_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      #2;
      chk("gap_hold", bus1.cpu_hold, 32'd1);
      chk("gap_nop", bus1.instr_out, 32'h0);
      chk("gap_we", bus1.im_we, 32'd0);
      step();
    end
  endtask

  task automatic do_load(input int gap);
    preload(8'd0, 32'hffff_ffff);
    preload(8'd1, 32'hffff_ffff);
    bus1.ld_start = 1'b1;
    #2;
    chk("start_hold", bus1.cpu_hold, 32'd0);
    step();
    bus1.ld_start = 1'b0;
    push1(8'h3c, gap, 1'b0, 32'h0, 32'h0);
    push1(8'h01, gap, 1'b0, 32'h0, 32'h0);
    push1(8'h00, gap, 1'b0, 32'h0, 32'h0);
    push1(8'h00, gap, 1'b1, 32'h3c01_0000, 32'd0);
    push1(8'h34, gap, 1'b0, 32'h0, 32'h0);
    push1(8'h30, gap, 1'b0, 32'h0, 32'h0);
    push1(8'h00, gap, 1'b0, 32'h0, 32'h0);
    push1(8'h00, gap, 1'b1, 32'h3430_0000, 32'd1);
    bus1.ld_end = 1'b1;
    #2;
    chk("end_we", bus1.im_we, 32'd0);
    chk("end_hold", bus1.cpu_hold, 32'd1);
    chk("end_restart", bus1.cpu_restart, 32'd0);
    step();
    bus1.ld_end = 1'b0;
    #2;
    chk("fl_restart", bus1.cpu_restart, 32'd1);
    chk("fl_hold", bus1.cpu_hold, 32'd1);
    chk("fl_ready", bus1.ld_ready, 32'd0);
    chk("fl_we", bus1.im_we, 32'd0);
    chk("fl_nop", bus1.instr_out, 32'h0);
    chk("fl_words", bus1.words_loaded, 32'd2);
    step();
    bus1.pc = 32'h0;
    #2;
    chk("run_hold", bus1.cpu_hold, 32'd0);
    chk("run_restart", bus1.cpu_restart, 32'd0);
    chk("run_err", bus1.ld_err, 32'd0);
    chk("run_addr0", bus1.im_addr, 32'd0);
    chk("run_word0", bus1.instr_out, 32'h3c01_0000);
    bus1.pc = 32'h4;
    #1;
    chk("run_word1", bus1.instr_out, 32'h3430_0000);
    bus1.pc = 32'h8;
  endtask

  initial begin
    reset = 1'b0;
    pre_we = 1'b0; pre_addr = 8'd0; pre_data = 32'h0;
    bus1.pc = 32'h8; bus1.ld_start = 1'b0; bus1.ld_end = 1'b0;
    bus1.ld_valid = 1'b0; bus1.ld_byte = 8'h00;
    bus2.pc = 32'h0; bus2.ld_start = 1'b0; bus2.ld_end = 1'b0;
    bus2.ld_valid = 1'b0; bus2.ld_byte = 8'h00;
    step();
    step();
    reset = 1'b1;
    preload(8'd2, 32'h8e08_0000);

    // reset state and combinational fetch
    #2;
    chk("rst_addr", bus1.im_addr, 32'd2);
    chk("rst_instr", bus1.instr_out, 32'h8e08_0000);
    chk("rst_hold", bus1.cpu_hold, 32'd0);
    chk("rst_restart", bus1.cpu_restart, 32'd0);
    chk("rst_we", bus1.im_we, 32'd0);
    chk("rst_ready", bus1.ld_ready, 32'd0);
    chk("rst_words", bus1.words_loaded, 32'd0);
    chk("rst_err", bus1.ld_err, 32'd0);
    bus1.pc = 32'hf000_0408;
    #1;
    chk("alias_addr", bus1.im_addr, 32'd2);
    chk("alias_instr", bus1.instr_out, 32'h8e08_0000);
    bus1.pc = 32'h8;
    step();

    // back-to-back then gapped loads
    do_load(0);
    step();
    do_load(2);
    step();

    // partial word discarded on ld_end
    preload(8'd1, 32'hdead_beef);
    bus1.ld_start = 1'b1;
    step();
    bus1.ld_start = 1'b0;
    push1(8'h11, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h22, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h33, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h44, 0, 1'b1, 32'h1122_3344, 32'd0);
    push1(8'h55, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h66, 0, 1'b0, 32'h0, 32'h0);
    bus1.ld_end = 1'b1;
    step();
    bus1.ld_end = 1'b0;
    #2;
    chk("part_restart", bus1.cpu_restart, 32'd1);
    step();
    #2;
    chk("part_err", bus1.ld_err, 32'd1);
    chk("part_words", bus1.words_loaded, 32'd1);
    chk("part_mem0", mem1[0], 32'h1122_3344);
    chk("part_mem1", mem1[1], 32'hdead_beef);
    chk("part_hold", bus1.cpu_hold, 32'd0);

    // new load clears the error; restart mid-load drops its byte
    bus1.ld_start = 1'b1;
    step();
    bus1.ld_start = 1'b0;
    #2;
    chk("clr_err", bus1.ld_err, 32'd0);
    chk("clr_words", bus1.words_loaded, 32'd0);
    step();
    push1(8'haa, 0, 1'b0, 32'h0, 32'h0);
    push1(8'hbb, 0, 1'b0, 32'h0, 32'h0);
    bus1.ld_start = 1'b1; bus1.ld_valid = 1'b1; bus1.ld_byte = 8'h77;
    #2;
    chk("rs_we", bus1.im_we, 32'd0);
    step();
    bus1.ld_start = 1'b0; bus1.ld_valid = 1'b0;
    push1(8'h01, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h02, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h03, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h04, 0, 1'b1, 32'h0102_0304, 32'd0);
    push1(8'h05, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h06, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h07, 0, 1'b0, 32'h0, 32'h0);
    // final byte arrives together with ld_end and still completes the word
    bus1.ld_end = 1'b1;
    push1(8'h08, 0, 1'b1, 32'h0506_0708, 32'd1);
    bus1.ld_end = 1'b0;
    #2;
    chk("ee_restart", bus1.cpu_restart, 32'd1);
    step();
    #2;
    chk("ee_err", bus1.ld_err, 32'd0);
    chk("ee_words", bus1.words_loaded, 32'd2);
    chk("ee_mem1", mem1[1], 32'h0506_0708);

    // full memory on the ADDR_W=2 instance
    step();
    bus2.ld_start = 1'b1;
    step();
    bus2.ld_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus2.ld_valid = 1'b1;
      bus2.ld_byte  = 8'(i);
      #2;
      if (i < 16) begin
        chk("full_hold", bus2.cpu_hold, 32'd1);
        chk("full_we", bus2.im_we, (i % 4 == 3) ? 32'd1 : 32'd0);
        if (i % 4 == 3) begin
          chk("full_wdata", bus2.im_wdata, ((i - 3) << 24) | ((i - 2) << 16) | ((i - 1) << 8) | i);
          chk("full_waddr", bus2.im_addr, i / 4);
        end
      end else if (i == 16) begin
        chk("full_flush", bus2.cpu_restart, 32'd1);
        chk("full_fl_we", bus2.im_we, 32'd0);
      end else begin
        chk("full_run_we", bus2.im_we, 32'd0);
        chk("full_run_hold", bus2.cpu_hold, 32'd0);
      end
      step();
    end
    bus2.ld_valid = 1'b0;
    #2;
    chk("full_err", bus2.ld_err, 32'd1);
    chk("full_words", bus2.words_loaded, 32'd4);
    chk("full_mem0", mem2[0], 32'h0001_0203);
    chk("full_mem3", mem2[3], 32'h0c0d_0e0f);

    // asynchronous reset in the middle of a load
    step();
    bus1.ld_start = 1'b1;
    step();
    bus1.ld_start = 1'b0;
    push1(8'hca, 0, 1'b0, 32'h0, 32'h0);
    push1(8'hfe, 0, 1'b0, 32'h0, 32'h0);
    push1(8'hba, 0, 1'b0, 32'h0, 32'h0);
    push1(8'hbe, 0, 1'b1, 32'hcafe_babe, 32'd0);
    push1(8'h12, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h34, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h56, 0, 1'b0, 32'h0, 32'h0);
    push1(8'h78, 0, 1'b1, 32'h1234_5678, 32'd1);
    #2;
    chk("ar_pre_hold", bus1.cpu_hold, 32'd1);
    reset = 1'b0;
    #1;
    chk("ar_hold", bus1.cpu_hold, 32'd0);
    chk("ar_we", bus1.im_we, 32'd0);
    chk("ar_restart", bus1.cpu_restart, 32'd0);
    chk("ar_ready", bus1.ld_ready, 32'd0);
    chk("ar_instr", bus1.instr_out, 32'h8e08_0000);
    step();
    reset = 1'b1;
    #2;
    chk("ar_restart2", bus1.cpu_restart, 32'd0);
    step();
    #2;
    chk("ar_restart3", bus1.cpu_restart, 32'd0);
    chk("ar_words", bus1.words_loaded, 32'd0);
    chk("ar_mem0", mem1[0], 32'hcafe_babe);
    chk("ar_mem1", mem1[1], 32'h1234_5678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
